uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter BUSY_WAIT, default 4, max cycles allowed for tx_busy to rise after tx_en.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  4  per-requester byte valid.
REQ-006 SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 SHALL have port req_two_stop  input  4  per-requester two-stop-bit select.
REQ-008 SHALL have port req_odd_parity  input  4  per-requester odd-parity select.
REQ-009 SHALL have port req_ready  output  4  one-hot accept strobe; byte taken when valid&ready.
REQ-010 SHALL have port tx_busy  input  1  transmitter frame in progress.
REQ-011 SHALL have port tx_en  output  1  one-cycle transmit start pulse.
REQ-012 SHALL have port tx_data  output  8  byte for transmitter.
REQ-013 SHALL have port tx_two_stop  output  1  stop-bit config for current frame.
REQ-014 SHALL have port tx_odd_parity  output  1  parity config for current frame.
REQ-015 SHALL have port grant_id  output  2  index of last accepted requester.
REQ-016 SHALL have port active  output  1  high in any state other than IDLE.
REQ-017 SHALL have port err_clr  input  1  clears err_timeout.
REQ-018 SHALL have port err_timeout  output  1  sticky: transmitter failed to acknowledge.

Function
REQ-019 SHALL implement FSM states IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-020 In IDLE with tx_busy=0 and any req_valid set, SHALL select requester by round-robin, searching from (grant_id+1) mod 4 upward with wrap.
REQ-021 SHALL drive req_ready[sel]=1 combinationally in that IDLE cycle only; all other req_ready bits 0.
REQ-022 On that edge, SHALL latch req_data byte, req_two_stop[sel], req_odd_parity[sel] into tx_data/tx_two_stop/tx_odd_parity, set grant_id=sel, go START.
REQ-023 In IDLE with tx_busy=1, SHALL assert no req_ready and stay IDLE.
REQ-024 START SHALL assert tx_en for exactly one cycle, then go WAIT_ACK; latency valid-accept cycle N -> tx_en cycle N+1.
REQ-025 WAIT_ACK: tx_busy=1 -> WAIT_DONE; else increment wait counter; counter reaching BUSY_WAIT -> set err_timeout, go IDLE.
REQ-026 Wait counter SHALL clear on entry to WAIT_ACK; width ceil(log2(BUSY_WAIT+1)).
REQ-027 WAIT_DONE: tx_busy=0 -> IDLE; no new accept same cycle (one idle cycle minimum between frames).
REQ-028 tx_data, tx_two_stop, tx_odd_parity SHALL hold stable from START until next accept.
REQ-029 err_timeout SHALL be sticky; err_clr clears it; simultaneous set and err_clr -> set wins.
REQ-030 req_valid deasserted before accept SHALL leave no state change; requester not granted keeps priority position.
REQ-031 Single requester continuously valid SHALL be granted every frame (no starvation of self by empty peers).

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, tx_en=0, req_ready=0, tx_data=0, tx_two_stop=0, tx_odd_parity=0, grant_id=3 (requester 0 first priority), active=0, err_timeout=0, wait counter 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no tx_en pulse after reset; transmitter reset is handled separately.

Verification
REQ-034 After reset, req_valid=4'b1111 held, tx_busy model 10 cycles per frame -> grants in order 0,1,2,3,0; each tx_en one cycle after its req_ready.
REQ-035 Only requester 2 valid, req_data[23:16]=8'hA5, two_stop=1, odd=1 -> tx_data=8'hA5, tx_two_stop=1, tx_odd_parity=1 at tx_en; grant_id=2.
REQ-036 tx_busy held 0 after tx_en, BUSY_WAIT=4 -> err_timeout=1 after 4 WAIT_ACK cycles, FSM IDLE; err_clr pulse -> err_timeout=0.
REQ-037 tx_busy=1 while IDLE with req_valid=4'b0001 -> req_ready stays 0 until tx_busy falls, then grant 0 next cycle.
REQ-038 rst_n=0 during WAIT_DONE -> next cycle all outputs at reset values, grant_id=3, active=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes and frame config from NREQ requesters to one UART transmitter.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int BUSY_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_two_stop,
  input  logic [NREQ-1:0]           req_odd_parity,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      tx_busy,
  output logic                      tx_en,
  output logic [7:0]                tx_data,
  output logic                      tx_two_stop,
  output logic                      tx_odd_parity,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      active,
  input  logic                      err_clr,
  output logic                      err_timeout
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_WAIT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_grant, w_sel;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic          r_two, r_odd, r_err;
  logic          w_accept, w_timeout;
  // Descending scan so the nearest requester after the last grant wins; offset NREQ wraps to the last grantee itself.
  always_comb begin
    w_sel = r_grant;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[r_grant + IW'(k)]) w_sel = r_grant + IW'(k);
  end
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = !tx_busy && |req_valid;
        w_next   = w_accept ? START : IDLE;
      end
      START:     w_next = WAIT_ACK;
      WAIT_ACK: begin
        w_timeout = !tx_busy && (r_cnt + CW'(1) == CW'(BUSY_WAIT));
        w_next    = tx_busy ? WAIT_DONE : (w_timeout ? IDLE : WAIT_ACK);
      end
      WAIT_DONE: w_next = tx_busy ? WAIT_DONE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_two   <= 1'b0;
      r_odd   <= 1'b0;
      r_grant <= IW'(NREQ - 1);
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= req_data[8*w_sel +: 8];
        r_two   <= req_two_stop[w_sel];
        r_odd   <= req_odd_parity[w_sel];
        r_grant <= w_sel;
      end
      r_cnt <= (r_state == WAIT_ACK) ? r_cnt + CW'(1) : '0;
      r_err <= w_timeout | (r_err & ~err_clr);
    end
  end
  assign req_ready     = (w_accept && rst_n) ? NREQ'(1) << w_sel : '0;
  assign tx_en         = r_state == START;
  assign active        = r_state != IDLE;
  assign tx_data       = r_data;
  assign tx_two_stop   = r_two;
  assign tx_odd_parity = r_odd;
  assign grant_id      = r_grant;
  assign err_timeout   = r_err;
endmodule
